// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, ex_ctrl bit positions and the memory-stage FSM state type.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CTRL_W = 5;

  // ex_ctrl packing: {halt, regwrite, memtoreg, memwrite, memread}
  localparam int unsigned CTRL_MEMREAD  = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_HALT     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  // True when the control word requests a data-memory access.
  function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_stage_if
  import cpu_pkg::*;
();

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dff.sv
// Single-bit register with synchronous active-high reset and load enable.
module dff (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Clear on reset, otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_16bit.sv
// 16-bit register with synchronous active-high reset and load enable.
module dff_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // Clear on reset, otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 16'd0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_4bit.sv
// 4-bit register with synchronous active-high reset and load enable.
module dff_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Clear on reset, otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: owns state, mem_req, stall and the optional timeout.
// Optional feature: define MEM_TIMEOUT_EN to add the BUSY timeout counter and sticky ERR state.
module mem_req_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load_mem_op,
  input  logic mem_ack,
  output logic mem_req,
  output logic stall,
  output logic mem_err
);

  localparam int unsigned CNT_W = 16;

  logic [1:0] state_bits_d;
  logic [1:0] state_bits_q;
  mem_state_t state_d;
  mem_state_t state_q;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_d;
  logic             err_q;
`endif

  assign state_q      = mem_state_t'(state_bits_q);
  assign state_bits_d = state_d;

  // State register.
  for (genvar i = 0; i < 2; i++) begin : g_state
    dff u_state (.clk(clk), .rst(rst), .en(1'b1), .d(state_bits_d[i]), .q(state_bits_q[i]));
  end

`ifdef MEM_TIMEOUT_EN
  // Unacknowledged-BUSY counter and sticky error flag.
  dff_16bit u_cnt (.clk(clk), .rst(rst), .en(1'b1), .d(cnt_d), .q(cnt_q));
  dff       u_err (.clk(clk), .rst(rst), .en(1'b1), .d(err_d), .q(err_q));
  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign mem_err        = 1'b0;
`endif

  // Bus request and upstream hold decoded from the current state; ack releases the hold at once.
  always_comb begin
    mem_req = 1'b0;
    stall   = 1'b0;
    if (state_q == BUSY) begin
      mem_req = 1'b1;
      stall   = ~mem_ack;
    end else if (state_q == ERR) begin
      stall   = 1'b1;
    end
  end

  // Next state: any advancing edge that loads a memory op (re)enters BUSY.
  always_comb begin
    state_d = state_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: state_d = load_mem_op ? BUSY : IDLE;
      BUSY: begin
        if (mem_ack) begin
          state_d = load_mem_op ? BUSY : IDLE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          end
`else
          state_d = BUSY;
`endif
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake and MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to enable the memory-timeout error path.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_W-1:0]      ex_rd,
  input  logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  stall,
  mem_access_stage_if.master    mem,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_W-1:0]      wb_rd,
  output logic                  wb_regwrite,
  output logic                  wb_halt,
  output logic                  mem_err
);

  logic              advance;
  logic              load_mem_op;
  logic [DATA_W-1:0] exm_alu_d;
  logic [DATA_W-1:0] exm_alu_q;
  logic [DATA_W-1:0] exm_sd_d;
  logic [DATA_W-1:0] exm_sd_q;
  logic [REG_W-1:0]  exm_rd_d;
  logic [REG_W-1:0]  exm_rd_q;
  logic [CTRL_W-1:0] exm_ctrl_d;
  logic [CTRL_W-1:0] exm_ctrl_q;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_regwrite_d;
  logic              wb_halt_d;
  logic              unused_memread;

  // Both pipeline registers move only when the stage is not holding.
  always_comb begin
    advance = ~stall;
  end

  // EX/MEM next values; a flush injects a bubble by clearing every control bit.
  always_comb begin
    exm_alu_d   = ex_alu_result;
    exm_sd_d    = ex_store_data;
    exm_rd_d    = ex_rd;
    exm_ctrl_d  = flush ? '0 : ex_ctrl;
    load_mem_op = is_mem_op(exm_ctrl_d);
  end

  // EX/MEM register.
  dff_16bit u_exm_alu (.clk(clk), .rst(rst), .en(advance), .d(exm_alu_d), .q(exm_alu_q));
  dff_16bit u_exm_sd  (.clk(clk), .rst(rst), .en(advance), .d(exm_sd_d),  .q(exm_sd_q));
  dff_4bit  u_exm_rd  (.clk(clk), .rst(rst), .en(advance), .d(exm_rd_d),  .q(exm_rd_q));
  for (genvar i = 0; i < int'(CTRL_W); i++) begin : g_exm_ctrl
    dff u_exm_ctrl (.clk(clk), .rst(rst), .en(advance), .d(exm_ctrl_d[i]), .q(exm_ctrl_q[i]));
  end

  // Request sequencing, stall generation and timeout.
  mem_req_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .load_mem_op(load_mem_op),
    .mem_ack    (mem.mem_ack),
    .mem_req    (mem.mem_req),
    .stall      (stall),
    .mem_err    (mem_err)
  );

  // Bus payload comes straight from EX/MEM, so it is stable for the whole request.
  assign mem.mem_we    = exm_ctrl_q[CTRL_MEMWRITE];
  assign mem.mem_addr  = exm_alu_q;
  assign mem.mem_wdata = exm_sd_q;

  // memread only matters on entry to BUSY, which is decided from the EX side.
  assign unused_memread = exm_ctrl_q[CTRL_MEMREAD];

  // MEM/WB next values; read data is taken only on the advancing (ack) edge of a load.
  always_comb begin
    wb_data_d     = exm_ctrl_q[CTRL_MEMTOREG] ? mem.mem_rdata : exm_alu_q;
    wb_regwrite_d = exm_ctrl_q[CTRL_REGWRITE];
    wb_halt_d     = exm_ctrl_q[CTRL_HALT];
  end

  // MEM/WB register.
  dff_16bit u_wb_data (.clk(clk), .rst(rst), .en(advance), .d(wb_data_d),     .q(wb_data));
  dff_4bit  u_wb_rd   (.clk(clk), .rst(rst), .en(advance), .d(exm_rd_q),      .q(wb_rd));
  dff       u_wb_rw   (.clk(clk), .rst(rst), .en(advance), .d(wb_regwrite_d), .q(wb_regwrite));
  dff       u_wb_halt (.clk(clk), .rst(rst), .en(advance), .d(wb_halt_d),     .q(wb_halt));

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: cycle table plus flush, reset and long-wait sequences.
module tb_mem_access_stage;

  localparam logic [4:0] C_NOP  = 5'b00000;
  localparam logic [4:0] C_ADD  = 5'b01000;
  localparam logic [4:0] C_LW   = 5'b01101;
  localparam logic [4:0] C_SW   = 5'b00010;
  localparam logic [4:0] C_HALT = 5'b10000;

  typedef struct {
    logic        flush;
    logic [4:0]  ctrl;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  rd;
    logic        ack;
    logic [15:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_wbd;
    logic [3:0]  e_wbrd;
    logic        e_rw;
    logic        e_halt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic [4:0]  ex_ctrl;
  logic        stall;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_regwrite;
  logic        wb_halt;
  logic        mem_err;

  int passed = 0;
  int total  = 0;

  vec_t tbl[15];

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_rd        (ex_rd),
    .ex_ctrl      (ex_ctrl),
    .stall        (stall),
    .mem          (mif),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_halt      (wb_halt),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fl, input logic [4:0] ctrl, input logic [15:0] alu,
                              input logic [15:0] sd, input logic [3:0] rd, input logic ack,
                              input logic [15:0] rdata, input logic e_stall, input logic e_req,
                              input logic e_we, input logic [15:0] e_addr, input logic [15:0] e_wdata,
                              input logic [15:0] e_wbd, input logic [3:0] e_wbrd, input logic e_rw,
                              input logic e_halt);
    vec_t v;
    v.flush = fl;  v.ctrl = ctrl;  v.alu = alu;  v.sd = sd;  v.rd = rd;
    v.ack = ack;  v.rdata = rdata;
    v.e_stall = e_stall;  v.e_req = e_req;  v.e_we = e_we;  v.e_addr = e_addr;  v.e_wdata = e_wdata;
    v.e_wbd = e_wbd;  v.e_wbrd = e_wbrd;  v.e_rw = e_rw;  v.e_halt = e_halt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_in(input logic fl, input logic [4:0] ctrl, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [3:0] rd, input logic ack,
                        input logic [15:0] rdata);
    flush         = fl;
    ex_ctrl       = ctrl;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    mif.mem_ack   = ack;
    mif.mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);

    // Cycle table: inputs for the cycle, expected combinational bus/stall and current wb_* values.
    tbl[0]  = mk(0, C_ADD,  16'h1234, 16'h0,    4'd3, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0,    4'd0, 0, 0);
    tbl[1]  = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0,    4'd0, 0, 0);
    tbl[2]  = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h1234, 4'd3, 1, 0);
    tbl[3]  = mk(0, C_LW,   16'h0040, 16'h0,    4'd5, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0,    4'd0, 0, 0);
    tbl[4]  = mk(0, C_ADD,  16'h0007, 16'h0,    4'd6, 0, 16'h0,    1, 1, 0, 16'h0040, 16'h0,    16'h0,    4'd0, 0, 0);
    tbl[5]  = mk(0, C_ADD,  16'h0007, 16'h0,    4'd6, 0, 16'h0,    1, 1, 0, 16'h0040, 16'h0,    16'h0,    4'd0, 0, 0);
    tbl[6]  = mk(0, C_ADD,  16'h0007, 16'h0,    4'd6, 1, 16'hBEEF, 0, 1, 0, 16'h0040, 16'h0,    16'h0,    4'd0, 0, 0);
    tbl[7]  = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'hBEEF, 4'd5, 1, 0);
    tbl[8]  = mk(0, C_SW,   16'h0100, 16'hCAFE, 4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0007, 4'd6, 1, 0);
    tbl[9]  = mk(0, C_LW,   16'h0102, 16'h0,    4'd9, 1, 16'h1111, 0, 1, 1, 16'h0100, 16'hCAFE, 16'h0,    4'd0, 0, 0);
    tbl[10] = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 1, 16'h2222, 0, 1, 0, 16'h0102, 16'h0,    16'h0100, 4'd0, 0, 0);
    tbl[11] = mk(0, C_HALT, 16'h0,    16'h0,    4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h2222, 4'd9, 1, 0);
    tbl[12] = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0,    4'd0, 0, 0);
    tbl[13] = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 1, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0,    4'd0, 0, 1);
    tbl[14] = mk(0, C_NOP,  16'h0,    16'h0,    4'd0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    16'h0,    4'd0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].flush, tbl[i].ctrl, tbl[i].alu, tbl[i].sd, tbl[i].rd, tbl[i].ack, tbl[i].rdata);
      #1;
      chk($sformatf("row%0d_stall", i),   32'(stall),        32'(tbl[i].e_stall));
      chk($sformatf("row%0d_req", i),     32'(mif.mem_req),  32'(tbl[i].e_req));
      if (tbl[i].e_req) begin
        chk($sformatf("row%0d_we", i),    32'(mif.mem_we),   32'(tbl[i].e_we));
        chk($sformatf("row%0d_addr", i),  32'(mif.mem_addr), 32'(tbl[i].e_addr));
        if (tbl[i].e_we)
          chk($sformatf("row%0d_wdata", i), 32'(mif.mem_wdata), 32'(tbl[i].e_wdata));
      end
      chk($sformatf("row%0d_wb_data", i), 32'(wb_data),      32'(tbl[i].e_wbd));
      chk($sformatf("row%0d_wb_rd", i),   32'(wb_rd),        32'(tbl[i].e_wbrd));
      chk($sformatf("row%0d_wb_rw", i),   32'(wb_regwrite),  32'(tbl[i].e_rw));
      chk($sformatf("row%0d_wb_halt", i), 32'(wb_halt),      32'(tbl[i].e_halt));
      chk($sformatf("row%0d_mem_err", i), 32'(mem_err),      32'(0));
      step();
    end

    // Flush while stalled is dropped; flush on an advancing edge bubbles the op.
    set_in(1'b0, C_LW, 16'h0200, 16'h0, 4'd2, 1'b0, 16'h0);
    step();
    set_in(1'b1, C_ADD, 16'h0055, 16'h0, 4'd4, 1'b0, 16'h0);
    #1;
    chk("flush_stalled_stall", 32'(stall), 32'(1));
    step();
    set_in(1'b0, C_ADD, 16'h0055, 16'h0, 4'd4, 1'b1, 16'hAAAA);
    #1;
    chk("flush_ack_stall", 32'(stall), 32'(0));
    step();
    set_in(1'b1, C_ADD, 16'h0066, 16'h0, 4'd7, 1'b0, 16'h0);
    #1;
    chk("flush_lw_wb_data", 32'(wb_data), 32'h0000AAAA);
    chk("flush_lw_wb_rd",   32'(wb_rd),   32'(2));
    step();
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
    #1;
    chk("flush_ignored_rw",   32'(wb_regwrite), 32'(1));
    chk("flush_ignored_rd",   32'(wb_rd),       32'(4));
    chk("flush_ignored_data", 32'(wb_data),     32'h00000055);
    step();
    chk("flush_adv_rw", 32'(wb_regwrite), 32'(0));

    // Reset in the second BUSY cycle of a load.
    set_in(1'b0, C_ADD, 16'h0077, 16'h0, 4'd1, 1'b0, 16'h0);
    step();
    set_in(1'b0, C_LW, 16'h0300, 16'h0, 4'd8, 1'b0, 16'h0);
    step();
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
    #1;
    chk("rstbusy_req1",    32'(mif.mem_req), 32'(1));
    chk("rstbusy_wb_pre",  32'(wb_data),     32'h00000077);
    step();
    chk("rstbusy_req2",    32'(mif.mem_req), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_req",     32'(mif.mem_req), 32'(0));
    chk("rst_stall",   32'(stall),       32'(0));
    chk("rst_wb_data", 32'(wb_data),     32'(0));
    chk("rst_wb_rd",   32'(wb_rd),       32'(0));
    chk("rst_wb_rw",   32'(wb_regwrite), 32'(0));
    chk("rst_wb_halt", 32'(wb_halt),     32'(0));
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b1, 16'hDEAD);
    #1;
    chk("rst_late_ack_stall", 32'(stall),       32'(0));
    chk("rst_late_ack_req",   32'(mif.mem_req), 32'(0));
    step();
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
    #1;
    chk("rst_late_ack_wb", 32'(wb_data), 32'(0));
    chk("rst_late_ack_req_after", 32'(mif.mem_req), 32'(0));

    // Load with no ack: timeout into ERR, or an indefinite wait without the feature.
    set_in(1'b0, C_LW, 16'h0400, 16'h0, 4'd10, 1'b0, 16'h0);
    step();
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_busy%0d_stall", i), 32'(stall),       32'(1));
      chk($sformatf("to_busy%0d_req", i),   32'(mif.mem_req), 32'(1));
      chk($sformatf("to_busy%0d_err", i),   32'(mem_err),     32'(0));
      step();
    end
    chk("to_err_req",   32'(mif.mem_req), 32'(0));
    chk("to_err_stall", 32'(stall),       32'(1));
    chk("to_err_flag",  32'(mem_err),     32'(1));
    mif.mem_ack = 1'b1;
    #1;
    chk("to_err_ack_stall", 32'(stall), 32'(1));
    step();
    mif.mem_ack = 1'b0;
    chk("to_err_hold_flag",  32'(mem_err), 32'(1));
    chk("to_err_hold_stall", 32'(stall),   32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("to_rst_flag",  32'(mem_err), 32'(0));
    chk("to_rst_stall", 32'(stall),   32'(0));
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("wait%0d_stall", i), 32'(stall),   32'(1));
      chk($sformatf("wait%0d_err", i),   32'(mem_err), 32'(0));
      step();
    end
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b1, 16'h1357);
    #1;
    chk("wait_ack_stall", 32'(stall), 32'(0));
    step();
    set_in(1'b0, C_NOP, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
    #1;
    chk("wait_wb_data", 32'(wb_data), 32'h00001357);
    chk("wait_wb_rd",   32'(wb_rd),   32'(10));
    chk("wait_req",     32'(mif.mem_req), 32'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
